// File: rtl/avr_pkg.sv
// Shared AVR core definitions: next-PC source encodings and the bubble instruction word.
package avr_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PCS_W   = 3;

    // Next-PC select codes driven by the CPU; 5..7 are reserved and fetch sequentially.
    localparam logic [PCS_W-1:0] PCS_INC   = 3'd0;
    localparam logic [PCS_W-1:0] PCS_REL   = 3'd1;
    localparam logic [PCS_W-1:0] PCS_ABS   = 3'd2;
    localparam logic [PCS_W-1:0] PCS_SKIP1 = 3'd3;
    localparam logic [PCS_W-1:0] PCS_SKIP2 = 3'd4;

    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/avr_next_pc.sv
// Combinational next-fetch-address selector for the AVR fetch stage.
// FETCH_SKIP2_EN enables the pc+3 skip over two-word instructions; otherwise code 4 fetches sequentially.
module avr_next_pc
    import avr_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 16
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PCS_W-1:0]    pc_src,
    input  logic [PC_WIDTH-1:0] jmp,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] next_pc_c
);

    // All sums are PC_WIDTH wide so wrap-around is implicit.
    always_comb begin
        next_pc_c = pc + PC_WIDTH'(1);
        if (stall) begin
            next_pc_c = pc;
        end else begin
            case (pc_src)
                PCS_REL:   next_pc_c = pc + PC_WIDTH'(1) + jmp;
                PCS_ABS:   next_pc_c = jmp;
                PCS_SKIP1: next_pc_c = pc + PC_WIDTH'(2);
`ifdef FETCH_SKIP2_EN
                PCS_SKIP2: next_pc_c = pc + PC_WIDTH'(3);
`endif
                default:   next_pc_c = pc + PC_WIDTH'(1);
            endcase
        end
    end

endmodule

// File: rtl/avr_fetch_unit.sv
// AVR instruction-fetch stage: owns the PC, addresses the one-cycle-latency program ROM.
// Optional FETCH_SKIP2_EN (see avr_next_pc) adds the pc+3 skip source.
module avr_fetch_unit #(
    parameter int unsigned PC_WIDTH = 16,
    parameter logic [15:0] NOP_WORD = avr_pkg::NOP_WORD
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                stall,
    input  logic [2:0]          pc_src,
    input  logic [PC_WIDTH-1:0] jmp,
    input  logic [15:0]         prog_data,
    output logic [PC_WIDTH-1:0] prog_addr,
    output logic [15:0]         cur_instr,
    output logic [PC_WIDTH-1:0] current_pc
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] next_pc_c;
    logic                prime_q;
    logic                prime_d;

    avr_next_pc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc (
        .pc        (pc_q),
        .pc_src    (pc_src),
        .jmp       (jmp),
        .stall     (stall),
        .next_pc_c (next_pc_c)
    );

    // The priming cycle re-fetches word 0, since the ROM may have been held in reset too.
    always_comb begin
        pc_d    = next_pc_c;
        prime_d = 1'b0;
        if (!RST) begin
            pc_d    = '0;
            prime_d = 1'b1;
        end else if (prime_q) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q    <= '0;
            prime_q <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            prime_q <= prime_d;
        end
    end

    assign prog_addr  = pc_d;
    assign current_pc = pc_q;
    assign cur_instr  = (!RST || prime_q) ? NOP_WORD : prog_data;

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Self-checking bench for avr_fetch_unit against a word-level PC model and a synchronous ROM model.
module tb_avr_fetch_unit;

`ifdef FETCH_SKIP2_EN
    localparam bit SKIP2_EN = 1'b1;
`else
    localparam bit SKIP2_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  pc_src;
    logic [15:0] jmp;
    logic [15:0] prog_data;
    logic [15:0] prog_addr;
    logic [15:0] cur_instr;
    logic [15:0] current_pc;

    logic [15:0] rom [65536];
    logic [15:0] model_pc;
    int          n_cmp;
    int          n_fail;

    avr_fetch_unit #(
        .PC_WIDTH (16),
        .NOP_WORD (16'h0000)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .stall      (stall),
        .pc_src     (pc_src),
        .jmp        (jmp),
        .prog_data  (prog_data),
        .prog_addr  (prog_addr),
        .cur_instr  (cur_instr),
        .current_pc (current_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: one cycle of read latency.
    always @(posedge clk) prog_data <= rom[prog_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Next word address from the instruction-set view of each PC source.
    function automatic logic [15:0] ref_next(input int pc, input int src, input int j, input bit st);
        int n;
        if (st) n = pc;
        else begin
            case (src)
                1: n = pc + 1 + ((j >= 32768) ? j - 65536 : j);
                2: n = j;
                3: n = pc + 2;
                4: n = SKIP2_EN ? pc + 3 : pc + 1;
                default: n = pc + 1;
            endcase
        end
        n = ((n % 65536) + 65536) % 65536;
        return 16'(n);
    endfunction

    task automatic step(input logic [2:0] src, input logic [15:0] j, input logic st, input string tag);
        logic [15:0] exp_pc;
        exp_pc = ref_next(int'(model_pc), int'(src), int'(j), st);
        rst = 1'b1; pc_src = src; jmp = j; stall = st;
        #1;
        n_cmp++;
        if (prog_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL %s prog_addr: got %h expected %h", tag, prog_addr, exp_pc);
        end
        @(posedge clk); #1;
        model_pc = exp_pc;
        n_cmp++;
        if (current_pc !== model_pc) begin
            n_fail++;
            $display("FAIL %s current_pc: got %h expected %h", tag, current_pc, model_pc);
        end
        n_cmp++;
        if (cur_instr !== rom[model_pc]) begin
            n_fail++;
            $display("FAIL %s cur_instr: got %h expected %h", tag, cur_instr, rom[model_pc]);
        end
    endtask

    task automatic goto_pc(input logic [15:0] a);
        step(3'd2, a, 1'b0, "goto");
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; pc_src = 3'd0; jmp = 16'h0;
        repeat (2) begin
            @(posedge clk); #1;
            n_cmp++;
            if (cur_instr !== 16'h0000 || prog_addr !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_hold: got instr %h addr %h expected 0000 0000", cur_instr, prog_addr);
            end
        end
        // Priming cycle: inputs must be ignored.
        rst = 1'b1; pc_src = 3'd2; jmp = 16'h1234; stall = 1'b1;
        #1;
        n_cmp++;
        if (cur_instr !== 16'h0000 || prog_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_prime: got instr %h addr %h expected 0000 0000", cur_instr, prog_addr);
        end
        @(posedge clk); #1;
        model_pc = 16'h0;
        n_cmp++;
        if (current_pc !== 16'h0000 || cur_instr !== 16'h1111) begin
            n_fail++;
            $display("FAIL reset_first: got %h@%h expected 1111@0000", cur_instr, current_pc);
        end
        step(3'd0, 16'h0, 1'b0, "reset_inc1");
        step(3'd0, 16'h0, 1'b0, "reset_inc2");
    endtask

    task automatic test_rel();
        goto_pc(16'd5);
        step(3'd1, 16'hFFFD, 1'b0, "rel_back");
        n_cmp++;
        if (current_pc !== 16'd3) begin
            n_fail++;
            $display("FAIL rel_back_pc: got %h expected 0003", current_pc);
        end
        goto_pc(16'd5);
        step(3'd1, 16'd4, 1'b0, "rel_fwd");
        n_cmp++;
        if (current_pc !== 16'd10) begin
            n_fail++;
            $display("FAIL rel_fwd_pc: got %h expected 000a", current_pc);
        end
    endtask

    task automatic test_abs();
        goto_pc(16'd2);
        step(3'd2, 16'h0100, 1'b0, "abs");
        n_cmp++;
        if (current_pc !== 16'h0100) begin
            n_fail++;
            $display("FAIL abs_pc: got %h expected 0100", current_pc);
        end
    endtask

    task automatic test_stall();
        goto_pc(16'd7);
        step(3'd1, 16'h0040, 1'b1, "stall1");
        step(3'd2, 16'h0200, 1'b1, "stall2");
        step(3'd0, 16'h0, 1'b0, "stall_release");
        n_cmp++;
        if (current_pc !== 16'd8) begin
            n_fail++;
            $display("FAIL stall_release_pc: got %h expected 0008", current_pc);
        end
    endtask

    task automatic test_skips();
        goto_pc(16'd4);
        step(3'd3, 16'h0, 1'b0, "skip1");
        goto_pc(16'd4);
        step(3'd4, 16'h0, 1'b0, "skip2");
        n_cmp++;
        if (current_pc !== (SKIP2_EN ? 16'd7 : 16'd5)) begin
            n_fail++;
            $display("FAIL skip2_pc: got %h expected %h", current_pc, SKIP2_EN ? 16'd7 : 16'd5);
        end
    endtask

    task automatic test_wrap_reserved();
        goto_pc(16'hFFFF);
        step(3'd0, 16'h0, 1'b0, "wrap");
        for (int c = 5; c < 8; c++) begin
            goto_pc(16'd9);
            step(3'(c), 16'h0300, 1'b0, "reserved");
        end
    endtask

    task automatic test_reset_midstream();
        goto_pc(16'h0050);
        rst = 1'b0; pc_src = 3'd1; jmp = 16'h0010; stall = 1'b0;
        #1;
        n_cmp++;
        if (prog_addr !== 16'h0000 || cur_instr !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_hold: got addr %h instr %h expected 0000 0000", prog_addr, cur_instr);
        end
        @(posedge clk); #1;
        rst = 1'b1; pc_src = 3'($urandom_range(0, 7)); jmp = 16'($urandom); stall = 1'($urandom);
        #1;
        n_cmp++;
        if (cur_instr !== 16'h0000 || prog_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_bubble: got instr %h addr %h expected 0000 0000", cur_instr, prog_addr);
        end
        @(posedge clk); #1;
        model_pc = 16'h0;
        n_cmp++;
        if (current_pc !== 16'h0000 || cur_instr !== rom[0]) begin
            n_fail++;
            $display("FAIL midreset_word0: got %h@%h expected %h@0000", cur_instr, current_pc, rom[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 3) == 0), "random");
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b0; stall = 1'b0; pc_src = 3'd0; jmp = 16'h0; model_pc = 16'h0;
        for (int a = 0; a < 65536; a++) rom[a] = 16'($urandom);
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        @(posedge clk); #1;
        test_reset();
        test_rel();
        test_abs();
        test_stall();
        test_skips();
        test_wrap_reserved();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
